// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- RV32I load/store sequencer.
//
// Takes one LOAD/STORE instruction at a time from execute. It computes the
// effective address and checks the encoding and alignment. It then issues a
// single-outstanding request on the memory bus. The extended load data, store
// completion or exception is returned to writeback.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_*           instruction handshake from execute (inst, rs1, rs2)
//   mem_req_*       bus request: word-aligned addr, wr, lane-shifted wdata,
//                   byte strobes
//   mem_rsp_*       bus response: one per request, stores included
//   done_*          result to writeback: rd, we, data, exc, full address
// ---------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   // instruction from execute
   input  logic            req_vld,
   output logic            req_rdy,
   input  logic [31:0]     req_inst,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   // memory request
   output logic            mem_req_vld,
   input  logic            mem_req_rdy,
   output logic [XLEN-1:0] mem_req_addr,
   output logic            mem_req_wr,
   output logic [XLEN-1:0] mem_req_wdata,
   output logic [3:0]      mem_req_wstrb,
   // memory response
   input  logic            mem_rsp_vld,
   input  logic [XLEN-1:0] mem_rsp_rdata,
   // result to writeback
   output logic            done_vld,
   input  logic            done_rdy,
   output logic [4:0]      done_rd,
   output logic            done_we,
   output logic [XLEN-1:0] done_data,
   output logic [1:0]      done_exc,
   output logic [XLEN-1:0] done_addr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RSP,
      S_DONE
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] EXC_NONE  = 2'd0;
   localparam logic [1:0] EXC_ALIGN = 2'd1;
   localparam logic [1:0] EXC_ILL   = 2'd2;

   state_e            state_q, state_d;
   logic              store_q, store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   ea_q, ea_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [1:0]        exc_q, exc_d;
   logic [XLEN-1:0]   data_q, data_d;

   // -------------------------------------------------------------------------
   // Decode of the incoming instruction (only used while IDLE)
   // -------------------------------------------------------------------------
   logic [6:0]      dec_opcode;
   logic [2:0]      dec_funct3;
   logic            dec_load, dec_store, dec_legal, dec_misal;
   logic [XLEN-1:0] dec_imm, dec_ea;
   logic [1:0]      dec_exc;

   // The rs1 register index is resolved by execute; only its value arrives here.
   logic unused_rs1_idx;
   assign unused_rs1_idx = ^req_inst[19:15];

   always_comb begin
      dec_opcode = req_inst[6:0];
      dec_funct3 = req_inst[14:12];
      dec_load   = (dec_opcode == OP_LOAD);
      dec_store  = (dec_opcode == OP_STORE);

      // I-type immediate for loads, S-type for stores, both sign-extended.
      if (dec_store) dec_imm = {{20{req_inst[31]}}, req_inst[31:25], req_inst[11:7]};
      else           dec_imm = {{20{req_inst[31]}}, req_inst[31:20]};
      dec_ea = req_rs1 + dec_imm;

      dec_legal = 1'b0;
      if (dec_load) begin
         case (dec_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_legal = 1'b1;
            default:                                dec_legal = 1'b0;
         endcase
      end else if (dec_store) begin
         dec_legal = (dec_funct3[2] == 1'b0) && (dec_funct3[1:0] != 2'b11);
      end

      // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
      case (dec_funct3[1:0])
         2'b01:   dec_misal = dec_ea[0];
         2'b10:   dec_misal = (dec_ea[1:0] != 2'b00);
         default: dec_misal = 1'b0;
      endcase

      if (!dec_legal)     dec_exc = EXC_ILL;
      else if (dec_misal) dec_exc = EXC_ALIGN;
      else                dec_exc = EXC_NONE;
   end

   // -------------------------------------------------------------------------
   // Load lane selection and extension from the response word
   // -------------------------------------------------------------------------
   logic [XLEN-1:0] rsp_shifted, load_ext;

   always_comb begin
      rsp_shifted = mem_rsp_rdata >> {ea_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_ext = {{24{rsp_shifted[7]}},  rsp_shifted[7:0]};
         3'b001:  load_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
         3'b100:  load_ext = {24'd0, rsp_shifted[7:0]};
         3'b101:  load_ext = {16'd0, rsp_shifted[15:0]};
         default: load_ext = mem_rsp_rdata;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every _d gets its hold value first so no path through the case
   // leaves a signal unassigned; that is what keeps this block latch-free.
   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      ea_d     = ea_q;
      rs2_d    = rs2_q;
      exc_d    = exc_q;
      data_d   = data_q;

      case (state_q)
         S_IDLE: begin
            if (req_vld) begin
               store_d  = dec_store;
               funct3_d = dec_funct3;
               // Stores and illegal encodings never write a register.
               rd_d     = dec_load ? req_inst[11:7] : 5'd0;
               ea_d     = dec_ea;
               rs2_d    = req_rs2;
               exc_d    = dec_exc;
               data_d   = '0;
               // An exception completes without touching the bus.
               state_d  = (dec_exc != EXC_NONE) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_rdy) state_d = S_RSP;
         end
         S_RSP: begin
            if (mem_rsp_vld) begin
               data_d  = store_q ? '0 : load_ext;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (done_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops
   // update together on the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         store_q  <= 1'b0;
         funct3_q <= 3'd0;
         rd_q     <= 5'd0;
         ea_q     <= '0;
         rs2_q    <= '0;
         exc_q    <= EXC_NONE;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         ea_q     <= ea_d;
         rs2_q    <= rs2_d;
         exc_q    <= exc_d;
         data_q   <= data_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registered state, so they stay stable while a
   // handshake is stalled. The valids are also masked by rst so they drop in
   // the same cycle that reset is asserted.
   // -------------------------------------------------------------------------
   logic in_req, in_done;
   assign in_req  = (state_q == S_REQ);
   assign in_done = (state_q == S_DONE);

   always_comb begin
      mem_req_wstrb = 4'b0000;
      mem_req_wdata = '0;
      if (in_req) begin
         case (funct3_q[1:0])
            2'b00: begin
               mem_req_wstrb = 4'b0001 << ea_q[1:0];
               mem_req_wdata = {4{rs2_q[7:0]}};
            end
            2'b01: begin
               mem_req_wstrb = 4'b0011 << ea_q[1:0];
               mem_req_wdata = {2{rs2_q[15:0]}};
            end
            default: begin
               mem_req_wstrb = 4'b1111;
               mem_req_wdata = rs2_q;
            end
         endcase
      end
   end

   assign req_rdy      = (state_q == S_IDLE);
   assign mem_req_vld  = in_req && !rst;
   assign mem_req_addr = in_req ? {ea_q[XLEN-1:2], 2'b00} : '0;
   assign mem_req_wr   = in_req && store_q;

   assign done_vld  = in_done && !rst;
   assign done_rd   = in_done ? rd_q : 5'd0;
   assign done_we   = in_done && !store_q && (exc_q == EXC_NONE) && (rd_q != 5'd0);
   assign done_data = in_done ? data_q : '0;
   assign done_exc  = in_done ? exc_q : EXC_NONE;
   assign done_addr = in_done ? ea_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Directed cases first, then randomized instructions with random bus and
// writeback stalls, all checked against a spec-level model.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_vld;
   logic        req_rdy;
   logic [31:0] req_inst, req_rs1, req_rs2;
   logic        mem_req_vld, mem_req_rdy, mem_req_wr;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_vld;
   logic [31:0] mem_rsp_rdata;
   logic        done_vld, done_rdy, done_we;
   logic [4:0]  done_rd;
   logic [31:0] done_data, done_addr;
   logic [1:0]  done_exc;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_inst(req_inst),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
      .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdata(mem_rsp_rdata),
      .done_vld(done_vld), .done_rdy(done_rdy), .done_rd(done_rd),
      .done_we(done_we), .done_data(done_data), .done_exc(done_exc),
      .done_addr(done_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: the architectural meaning of one instruction
   // ------------------------------------------------------------------------
   typedef struct {
      bit        is_load;
      bit        is_store;
      bit [2:0]  f3;
      int        size;
      bit [31:0] ea;
      bit [1:0]  exc;
      bit [4:0]  rd;
      bit        we;
      bit [3:0]  strb;
      bit [31:0] wdata;
   } exp_t;

   function automatic exp_t model(input bit [31:0] inst, input bit [31:0] rs1, input bit [31:0] rs2);
      exp_t e;
      int   imm;
      int   off;
      bit   legal;
      e.is_load  = (inst[6:0] == 7'h03);
      e.is_store = (inst[6:0] == 7'h23);
      e.f3       = inst[14:12];
      imm = e.is_store ? int'({inst[31:25], inst[11:7]}) : int'(inst[31:20]);
      if (imm >= 2048) imm -= 4096;
      e.ea = rs1 + 32'(imm);
      case (e.f3[1:0])
         2'd0:    e.size = 1;
         2'd1:    e.size = 2;
         default: e.size = 4;
      endcase
      legal = (e.is_load  && (e.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              (e.is_store && (e.f3 inside {3'd0, 3'd1, 3'd2}));
      if (!legal)                  e.exc = 2'd2;
      else if (e.ea % e.size != 0) e.exc = 2'd1;
      else                         e.exc = 2'd0;
      e.rd = e.is_load ? inst[11:7] : 5'd0;
      e.we = e.is_load && (e.exc == 0) && (e.rd != 0);
      off = int'(e.ea % 4);
      e.strb  = '0;
      e.wdata = '0;
      for (int b = 0; b < 4; b++) begin
         if (b >= off && b < off + e.size) e.strb[b] = 1'b1;
         e.wdata[8*b +: 8] = rs2[8*(b % e.size) +: 8];
      end
      return e;
   endfunction

   function automatic bit [31:0] load_value(input exp_t e, input bit [31:0] rdata);
      longint v;
      longint span;
      if (e.size == 4) return rdata;
      span = longint'(1) << (8 * e.size);
      v = longint'(rdata >> (8 * (e.ea % 4))) % span;
      if (!e.f3[2] && v >= span / 2) v -= span;
      return 32'(v);
   endfunction

   // Encoders: rs1 index field is filled with 1, it carries no meaning here.
   function automatic bit [31:0] enc_load(input bit [2:0] f3, input bit [4:0] rd, input bit [11:0] imm);
      return {imm, 5'd1, f3, rd, 7'b0000011};
   endfunction

   function automatic bit [31:0] enc_store(input bit [2:0] f3, input bit [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_done(input string tag, input exp_t e, input bit [31:0] rdata);
      check({tag, ".done_vld"}, done_vld, 1);
      check({tag, ".done_exc"}, done_exc, e.exc);
      check({tag, ".done_addr"}, done_addr, e.ea);
      check({tag, ".done_we"}, done_we, e.we);
      check({tag, ".req_rdy"}, req_rdy, 0);
      if (e.exc == 0) begin
         check({tag, ".done_rd"}, done_rd, e.rd);
         check({tag, ".done_data"}, done_data, e.is_load ? load_value(e, rdata) : 32'd0);
      end
   endtask

   task automatic check_req(input string tag, input exp_t e);
      check({tag, ".mem_req_vld"}, mem_req_vld, 1);
      check({tag, ".mem_req_addr"}, mem_req_addr, {e.ea[31:2], 2'b00});
      check({tag, ".mem_req_wr"}, mem_req_wr, e.is_store);
      check({tag, ".mem_req_wstrb"}, mem_req_wstrb, e.strb);
      check({tag, ".req_rdy"}, req_rdy, 0);
      check({tag, ".done_vld"}, done_vld, 0);
      if (e.is_store) check({tag, ".mem_req_wdata"}, mem_req_wdata, e.wdata);
   endtask

   // One full instruction: accept, bus (unless exception), writeback.
   // Stray mem_rsp_vld pulses outside RSP exercise the ignore rule.
   task automatic run_op(input string tag, input bit [31:0] inst, input bit [31:0] rs1,
                         input bit [31:0] rs2, input bit [31:0] rdata,
                         input int req_stall, input int rsp_delay, input int done_stall);
      exp_t e;
      int   budget;
      e = model(inst, rs1, rs2);
      budget = 0;
      while (!req_rdy && budget < 20) begin
         step();
         budget++;
      end
      check({tag, ".idle_rdy"}, req_rdy, 1);
      req_vld  = 1'b1;
      req_inst = inst;
      req_rs1  = rs1;
      req_rs2  = rs2;
      step();                                   // T1
      req_vld  = 1'b0;
      req_inst = $urandom;
      req_rs1  = $urandom;
      req_rs2  = $urandom;
      if (e.exc != 0) begin
         check({tag, ".no_mem_req"}, mem_req_vld, 0);
         check_done(tag, e, rdata);
      end else begin
         for (int i = 0; i < req_stall; i++) begin
            check_req({tag, ".stall"}, e);
            mem_rsp_vld   = 1'b1;               // ignored outside RSP
            mem_rsp_rdata = $urandom;
            step();
            mem_rsp_vld   = 1'b0;
         end
         check_req(tag, e);
         mem_req_rdy = 1'b1;
         step();                                // now waiting for response
         mem_req_rdy = 1'b0;
         for (int i = 0; i < rsp_delay; i++) begin
            check({tag, ".rsp_wait_req"}, mem_req_vld, 0);
            check({tag, ".rsp_wait_done"}, done_vld, 0);
            step();
         end
         check({tag, ".rsp_req_vld"}, mem_req_vld, 0);
         mem_rsp_vld   = 1'b1;
         mem_rsp_rdata = rdata;
         step();
         mem_rsp_vld   = 1'b0;
         mem_rsp_rdata = $urandom;
         check({tag, ".no_new_req"}, mem_req_vld, 0);
         check_done(tag, e, rdata);
      end
      for (int i = 0; i < done_stall; i++) begin
         mem_rsp_vld = 1'b1;                    // ignored outside RSP
         step();
         mem_rsp_vld = 1'b0;
         check_done({tag, ".hold"}, e, rdata);
      end
      done_rdy = 1'b1;
      step();
      done_rdy = 1'b0;
      check({tag, ".done_drop"}, done_vld, 0);
      check({tag, ".rdy_back"}, req_rdy, 1);
   endtask

   initial begin
      exp_t     e;
      bit [2:0] f3;
      bit [31:0] inst, rs1;
      int       kind;

      rst = 1'b1;
      req_vld = 0; req_inst = 0; req_rs1 = 0; req_rs2 = 0;
      mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_rdata = 0; done_rdy = 0;
      repeat (3) step();
      rst = 1'b0;
      step();

      check("reset.req_rdy", req_rdy, 1);
      check("reset.mem_req_vld", mem_req_vld, 0);
      check("reset.mem_req_addr", mem_req_addr, 0);
      check("reset.mem_req_wstrb", mem_req_wstrb, 0);
      check("reset.done_vld", done_vld, 0);
      check("reset.done_data", done_data, 0);
      check("reset.done_exc", done_exc, 0);

      // Directed cases
      run_op("lw",  enc_load(3'b010, 5'd5, 12'd8), 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0);
      run_op("lb",  enc_load(3'b000, 5'd6, 12'd3), 32'h2000, 32'h0, 32'h80FF1234, 0, 0, 0);
      run_op("lbu", enc_load(3'b100, 5'd7, 12'd3), 32'h2000, 32'h0, 32'h80FF1234, 0, 0, 0);
      run_op("lh",  enc_load(3'b001, 5'd8, 12'd2), 32'h2000, 32'h0, 32'h80FF1234, 0, 1, 0);
      run_op("lhu", enc_load(3'b101, 5'd9, 12'd2), 32'h2000, 32'h0, 32'h80FF1234, 0, 0, 0);
      run_op("sh",  enc_store(3'b001, 12'd2), 32'h3000, 32'h0000ABCD, 32'h0, 0, 0, 0);
      run_op("sb",  enc_store(3'b000, 12'hFFF), 32'h3001, 32'h0000005A, 32'h0, 0, 0, 0);
      run_op("sw",  enc_store(3'b010, 12'd4), 32'h3000, 32'h12345678, 32'h0, 0, 0, 0);
      run_op("lw_misal", enc_load(3'b010, 5'd3, 12'd2), 32'h4000, 32'h0, 32'h0, 0, 0, 0);
      run_op("lh_misal", enc_load(3'b001, 5'd3, 12'd1), 32'h4000, 32'h0, 32'h0, 0, 0, 0);
      run_op("ld_ill", enc_load(3'b011, 5'd3, 12'd0), 32'h4000, 32'h0, 32'h0, 0, 0, 0);
      run_op("sw_ill", enc_store(3'b100, 12'd0), 32'h4000, 32'h0, 32'h0, 0, 0, 0);
      run_op("opc_ill", 32'h00000033, 32'h4000, 32'h0, 32'h0, 0, 0, 0);
      run_op("lw_wrap", enc_load(3'b010, 5'd4, 12'd8), 32'hFFFFFFFC, 32'h0, 32'hCAFEF00D, 0, 0, 0);
      run_op("bp", enc_load(3'b010, 5'd10, 12'd0), 32'h5000, 32'h0, 32'h01020304, 3, 0, 2);
      run_op("lw_x0", enc_load(3'b010, 5'd0, 12'd0), 32'h6000, 32'h0, 32'h11223344, 0, 0, 0);

      // Reset while waiting for the response, then a late response
      req_vld = 1'b1; req_inst = enc_load(3'b010, 5'd5, 12'd0); req_rs1 = 32'h7000;
      step();
      req_vld = 1'b0;
      mem_req_rdy = 1'b1;
      step();
      mem_req_rdy = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_rsp.mem_req_vld", mem_req_vld, 0);
      check("rst_rsp.done_vld", done_vld, 0);
      step();
      rst = 1'b0;
      check("rst_rsp.req_rdy", req_rdy, 1);
      mem_rsp_vld = 1'b1; mem_rsp_rdata = 32'hBAD0BAD0;
      step();
      mem_rsp_vld = 1'b0;
      check("late_rsp.done_vld", done_vld, 0);
      check("late_rsp.req_rdy", req_rdy, 1);
      step();
      check("late_rsp.done_vld2", done_vld, 0);

      // Reset while a result is pending drops done_vld in the same cycle
      req_vld = 1'b1; req_inst = enc_load(3'b011, 5'd5, 12'd0);
      step();
      req_vld = 1'b0;
      check("rst_done.pre", done_vld, 1);
      rst = 1'b1;
      #1;
      check("rst_done.done_vld", done_vld, 0);
      step();
      rst = 1'b0;
      check("rst_done.req_rdy", req_rdy, 1);
      check("rst_done.after", done_vld, 0);

      // Randomized instructions
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         f3   = 3'($urandom_range(0, 7));
         inst = $urandom;
         inst[14:12] = f3;
         if (kind < 5)      inst[6:0] = 7'b0000011;
         else if (kind < 9) inst[6:0] = 7'b0100011;
         else               inst[6:0] = 7'b0010011;
         rs1 = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            // keep the sum aligned more often so the bus path gets exercised
            rs1[1:0]   = 2'b00;
            inst[21:20] = 2'b00;
            inst[8:7]   = 2'b00;
         end
         e = model(inst, rs1, 32'h0);
         run_op($sformatf("rnd%0d", n), inst, rs1, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
